// File: rtl/mem_stage_mc_if.sv
// mem_stage_mc_if
//   Bundles the EX/MEM inputs, the stall handshake and the MEM/WB pipeline
//   register outputs of the multi-cycle memory stage.
//   Ports / signals:
//     ALUO_EXMEM, Rd2_EXMEM           ALU result (byte address) and store data
//     MemRead_EXMEM, MemWrite_EXMEM   load / store request
//     MemtoReg_EXMEM, Valid_EXMEM     writeback select, live-instruction flag
//     Stall_MEM                       upstream holds EX/MEM while high
//     RdD_MEMWB, ALUO_MEMWB           registered load data and ALU result
//     MemtoReg_MEMWB, Valid_MEMWB     registered control
//     Err_MEMWB                       registered alignment fault flag
//   Modports: master = upstream/driver side, slave = memory stage.
interface mem_stage_mc_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] ALUO_EXMEM;
   logic [DATA_W-1:0] Rd2_EXMEM;
   logic              MemRead_EXMEM;
   logic              MemWrite_EXMEM;
   logic              MemtoReg_EXMEM;
   logic              Valid_EXMEM;
   logic              Stall_MEM;
   logic [DATA_W-1:0] RdD_MEMWB;
   logic [DATA_W-1:0] ALUO_MEMWB;
   logic              MemtoReg_MEMWB;
   logic              Valid_MEMWB;
   logic              Err_MEMWB;

   modport master (
      output ALUO_EXMEM, Rd2_EXMEM, MemRead_EXMEM, MemWrite_EXMEM,
             MemtoReg_EXMEM, Valid_EXMEM,
      input  Stall_MEM, RdD_MEMWB, ALUO_MEMWB, MemtoReg_MEMWB,
             Valid_MEMWB, Err_MEMWB
   );

   modport slave (
      input  ALUO_EXMEM, Rd2_EXMEM, MemRead_EXMEM, MemWrite_EXMEM,
             MemtoReg_EXMEM, Valid_EXMEM,
      output Stall_MEM, RdD_MEMWB, ALUO_MEMWB, MemtoReg_MEMWB,
             Valid_MEMWB, Err_MEMWB
   );
endinterface

// File: rtl/mem_stage_mc.sv
// mem_stage_mc
//   Multi-cycle memory stage between the EX/MEM and MEM/WB boundaries. Owns
//   a DEPTH x DATA_W word array with LATENCY cycles per access, stalls
//   upstream while an access is in flight and registers load data, ALU
//   result and writeback control into MEM/WB.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset (array contents are kept)
//     bus   mem_stage_mc_if.slave: EX/MEM inputs, Stall_MEM, MEM/WB outputs
//   Optional feature: define MEM_ALIGN_CHECK_EN to reject odd byte addresses
//   with a one-cycle Err_MEMWB result; otherwise Err_MEMWB is tied to 0.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | sample EX/MEM; pass non-accesses, accept or finish accesses
//   BUSY  | access in flight; cnt counts down, completes at cnt == 0
module mem_stage_mc #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input logic           clk,
   input logic           rst,
   mem_stage_mc_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 2) ? CNT_W'(LATENCY - 2) : '0;

   typedef enum logic {IDLE, BUSY} stateType;

   stateType          state, stateNext;
   logic [CNT_W-1:0]  cnt, cntNext;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] byteAddr;
   logic [IDX_W-1:0]  accIdx, rdIdx, wrIdx;
   logic [DATA_W-1:0] memRdData, wrData;
   logic              access, misaligned, stall, wrEn, capLoad;
   logic              unusedAddrBits;

   // Request captured at accept time; upstream holds EX/MEM anyway, but the
   // captured copy keeps the in-flight access self-contained.
   logic [IDX_W-1:0]  capIdx;
   logic [DATA_W-1:0] capWdata, capAluo;
   logic              capStore, capMemtoReg;

   logic [DATA_W-1:0] wbRdD, wbAluo;
   logic              wbValid, wbMemtoReg;

   logic [DATA_W-1:0] rdDQ, aluoQ;
   logic              memtoRegQ, validQ;

   assign byteAddr       = bus.ALUO_EXMEM[ADDR_W-1:0];
   assign accIdx         = byteAddr[IDX_W:1];
   // High address bits are deliberately ignored so the array wraps.
   assign unusedAddrBits = ^byteAddr;

   assign access = bus.Valid_EXMEM & (bus.MemRead_EXMEM | bus.MemWrite_EXMEM);

`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = byteAddr[0];
`else
   assign misaligned = 1'b0;
`endif

   assign rdIdx     = (state == BUSY) ? capIdx : accIdx;
   assign memRdData = mem[rdIdx];

   always_comb begin
      stateNext  = state;
      cntNext    = cnt;
      stall      = 1'b0;
      capLoad    = 1'b0;
      wrEn       = 1'b0;
      wrIdx      = capIdx;
      wrData     = capWdata;
      wbValid    = 1'b0;
      wbRdD      = '0;
      wbAluo     = '0;
      wbMemtoReg = 1'b0;

      case (state)
         IDLE: begin
            if (bus.Valid_EXMEM) begin
               if (access && misaligned) begin
                  wbValid    = 1'b1;
                  wbAluo     = bus.ALUO_EXMEM;
                  wbMemtoReg = bus.MemtoReg_EXMEM;
               end else if (access && (LATENCY == 1)) begin
                  wbValid    = 1'b1;
                  wbAluo     = bus.ALUO_EXMEM;
                  wbMemtoReg = bus.MemtoReg_EXMEM;
                  if (bus.MemWrite_EXMEM) begin
                     wrEn   = 1'b1;
                     wrIdx  = accIdx;
                     wrData = bus.Rd2_EXMEM;
                  end else begin
                     wbRdD = memRdData;
                  end
               end else if (access) begin
                  // Accept cycle: MEM/WB takes a bubble while we stall.
                  stall     = 1'b1;
                  capLoad   = 1'b1;
                  cntNext   = CNT_INIT;
                  stateNext = BUSY;
               end else begin
                  wbValid    = 1'b1;
                  wbAluo     = bus.ALUO_EXMEM;
                  wbMemtoReg = bus.MemtoReg_EXMEM;
               end
            end
         end

         BUSY: begin
            if (cnt != '0) begin
               stall   = 1'b1;
               cntNext = cnt - 1'b1;
            end else begin
               // Completion cycle; read-and-write requests count as stores.
               wbValid    = 1'b1;
               wbAluo     = capAluo;
               wbMemtoReg = capMemtoReg;
               stateNext  = IDLE;
               if (capStore) begin
                  wrEn = 1'b1;
               end else begin
                  wbRdD = memRdData;
               end
            end
         end

         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         capIdx      <= '0;
         capWdata    <= '0;
         capAluo     <= '0;
         capStore    <= 1'b0;
         capMemtoReg <= 1'b0;
         rdDQ        <= '0;
         aluoQ       <= '0;
         memtoRegQ   <= 1'b0;
         validQ      <= 1'b0;
      end else begin
         state     <= stateNext;
         cnt       <= cntNext;
         rdDQ      <= wbRdD;
         aluoQ     <= wbAluo;
         memtoRegQ <= wbMemtoReg;
         validQ    <= wbValid;
         if (capLoad) begin
            capIdx      <= accIdx;
            capWdata    <= bus.Rd2_EXMEM;
            capAluo     <= bus.ALUO_EXMEM;
            capStore    <= bus.MemWrite_EXMEM;
            capMemtoReg <= bus.MemtoReg_EXMEM;
         end
      end
   end

   // Reset on the completion edge discards the in-flight store.
   always_ff @(posedge clk) begin
      if (wrEn && !rst) begin
         mem[wrIdx] <= wrData;
      end
   end

`ifdef MEM_ALIGN_CHECK_EN
   logic errQ;

   always_ff @(posedge clk) begin
      if (rst) begin
         errQ <= 1'b0;
      end else begin
         errQ <= (state == IDLE) && access && misaligned;
      end
   end

   assign bus.Err_MEMWB = errQ;
`else
   assign bus.Err_MEMWB = 1'b0;
`endif

   assign bus.Stall_MEM      = stall;
   assign bus.RdD_MEMWB      = rdDQ;
   assign bus.ALUO_MEMWB     = aluoQ;
   assign bus.MemtoReg_MEMWB = memtoRegQ;
   assign bus.Valid_MEMWB    = validQ;

endmodule

// File: tb/tb_mem_stage_mc.sv
module tb_mem_stage_mc;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   mem_stage_mc_if #(.DATA_W(16)) bus2 ();
   mem_stage_mc_if #(.DATA_W(16)) bus4 ();

   mem_stage_mc #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .LATENCY(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   mem_stage_mc #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .LATENCY(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic        v, rd, wr, m2r;
      logic [15:0] aluo, rd2;
      int          expStall;
      logic        expValid;
      logic [15:0] expRdD, expAluo;
      logic        expM2r, expErr;
   } vec_t;

   vec_t tbl[12];

   function automatic vec_t mk(input string name, input logic v, rd, wr, m2r,
                               input logic [15:0] aluo, rd2, input int expStall,
                               input logic expValid, input logic [15:0] expRdD, expAluo,
                               input logic expM2r, expErr);
      vec_t t;
      t.name = name; t.v = v; t.rd = rd; t.wr = wr; t.m2r = m2r;
      t.aluo = aluo; t.rd2 = rd2; t.expStall = expStall; t.expValid = expValid;
      t.expRdD = expRdD; t.expAluo = expAluo; t.expM2r = expM2r; t.expErr = expErr;
      return t;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input int sel, input logic v, rd, wr, m2r, input logic [15:0] aluo, rd2);
      if (sel == 1) begin
         bus4.Valid_EXMEM = v; bus4.MemRead_EXMEM = rd; bus4.MemWrite_EXMEM = wr;
         bus4.MemtoReg_EXMEM = m2r; bus4.ALUO_EXMEM = aluo; bus4.Rd2_EXMEM = rd2;
      end else begin
         bus2.Valid_EXMEM = v; bus2.MemRead_EXMEM = rd; bus2.MemWrite_EXMEM = wr;
         bus2.MemtoReg_EXMEM = m2r; bus2.ALUO_EXMEM = aluo; bus2.Rd2_EXMEM = rd2;
      end
   endtask

   task automatic driveBubble(input int sel);
      drive(sel, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   function automatic logic getStall(input int sel);
      return (sel == 1) ? bus4.Stall_MEM : bus2.Stall_MEM;
   endfunction
   function automatic logic getValid(input int sel);
      return (sel == 1) ? bus4.Valid_MEMWB : bus2.Valid_MEMWB;
   endfunction
   function automatic logic [15:0] getRdD(input int sel);
      return (sel == 1) ? bus4.RdD_MEMWB : bus2.RdD_MEMWB;
   endfunction
   function automatic logic [15:0] getAluo(input int sel);
      return (sel == 1) ? bus4.ALUO_MEMWB : bus2.ALUO_MEMWB;
   endfunction
   function automatic logic getM2r(input int sel);
      return (sel == 1) ? bus4.MemtoReg_MEMWB : bus2.MemtoReg_MEMWB;
   endfunction
   function automatic logic getErr(input int sel);
      return (sel == 1) ? bus4.Err_MEMWB : bus2.Err_MEMWB;
   endfunction

   // Called shortly after a falling edge with the stage in IDLE. Holds the
   // request while Stall_MEM is high, then checks MEM/WB one cycle after the
   // completion cycle and returns at that point (stage back in IDLE).
   task automatic issue(input int sel, input vec_t t);
      int n;
      drive(sel, t.v, t.rd, t.wr, t.m2r, t.aluo, t.rd2);
      #1;
      n = 0;
      while (getStall(sel) === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
         #1;
         check({t.name, "_stall_bubble"}, 32'(getValid(sel)), 32'd0);
      end
      check({t.name, "_stall_cycles"}, 32'(n), 32'(t.expStall));
      @(negedge clk);
      driveBubble(sel);
      #1;
      check({t.name, "_valid"}, 32'(getValid(sel)), 32'(t.expValid));
      check({t.name, "_rdd"},   32'(getRdD(sel)),   32'(t.expRdD));
      check({t.name, "_aluo"},  32'(getAluo(sel)),  32'(t.expAluo));
      check({t.name, "_m2r"},   32'(getM2r(sel)),   32'(t.expM2r));
      check({t.name, "_err"},   32'(getErr(sel)),   32'(t.expErr));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      tbl[0]  = mk("st_beef",  1,0,1,0, 16'h0010, 16'hBEEF, 1, 1, 16'h0000, 16'h0010, 0, 0);
      tbl[1]  = mk("ld_beef",  1,1,0,1, 16'h0010, 16'h0000, 1, 1, 16'hBEEF, 16'h0010, 1, 0);
      tbl[2]  = mk("st_wrap",  1,0,1,0, 16'h0802, 16'h00AA, 1, 1, 16'h0000, 16'h0802, 0, 0);
      tbl[3]  = mk("ld_wrap",  1,1,0,1, 16'h0002, 16'h0000, 1, 1, 16'h00AA, 16'h0002, 1, 0);
      tbl[4]  = mk("rdwr",     1,1,1,1, 16'h0030, 16'h0F0F, 1, 1, 16'h0000, 16'h0030, 1, 0);
      tbl[5]  = mk("ld_rdwr",  1,1,0,0, 16'h0030, 16'h0000, 1, 1, 16'h0F0F, 16'h0030, 0, 0);
      tbl[6]  = mk("pass",     1,0,0,1, 16'h1234, 16'hFFFF, 0, 1, 16'h0000, 16'h1234, 1, 0);
      tbl[7]  = mk("bubble",   0,1,1,1, 16'h5A5A, 16'hA5A5, 0, 0, 16'h0000, 16'h0000, 0, 0);
      tbl[8]  = mk("st_1111",  1,0,1,0, 16'h0020, 16'h1111, 1, 1, 16'h0000, 16'h0020, 0, 0);
      tbl[9]  = mk("st_top",   1,0,1,0, 16'h07FE, 16'h1357, 1, 1, 16'h0000, 16'h07FE, 0, 0);
      tbl[10] = mk("ld_top",   1,1,0,1, 16'hFFFE, 16'h0000, 1, 1, 16'h1357, 16'hFFFE, 1, 0);
`ifdef MEM_ALIGN_CHECK_EN
      tbl[11] = mk("ld_odd",   1,1,0,1, 16'h0011, 16'h0000, 0, 1, 16'h0000, 16'h0011, 1, 1);
`else
      tbl[11] = mk("ld_odd",   1,1,0,1, 16'h0011, 16'h0000, 1, 1, 16'hBEEF, 16'h0011, 1, 0);
`endif

      driveBubble(0);
      driveBubble(1);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("reset_stall", 32'(bus2.Stall_MEM),      32'd0);
      check("reset_valid", 32'(bus2.Valid_MEMWB),    32'd0);
      check("reset_rdd",   32'(bus2.RdD_MEMWB),      32'd0);
      check("reset_aluo",  32'(bus2.ALUO_MEMWB),     32'd0);
      check("reset_m2r",   32'(bus2.MemtoReg_MEMWB), 32'd0);
      check("reset_err",   32'(bus2.Err_MEMWB),      32'd0);
      check("reset_valid4",32'(bus4.Valid_MEMWB),    32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;

      for (int i = 0; i < 12; i++) begin
         issue(0, tbl[i]);
      end

      // Reset during the BUSY (completion) cycle of a store over 16'h1111.
      drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h5555);
      #1;
      check("rstmid_accept_stall", 32'(bus2.Stall_MEM), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rstmid_busy_stall", 32'(bus2.Stall_MEM), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      driveBubble(0);
      #1;
      check("rstmid_stall", 32'(bus2.Stall_MEM),      32'd0);
      check("rstmid_valid", 32'(bus2.Valid_MEMWB),    32'd0);
      check("rstmid_rdd",   32'(bus2.RdD_MEMWB),      32'd0);
      check("rstmid_aluo",  32'(bus2.ALUO_MEMWB),     32'd0);
      check("rstmid_m2r",   32'(bus2.MemtoReg_MEMWB), 32'd0);
      issue(0, mk("rstmid_reload", 1,1,0,0, 16'h0020, 16'h0000, 1, 1, 16'h1111, 16'h0020, 0, 0));

      // Reset clears a live MEM/WB entry.
      issue(0, mk("pre_rst_pass", 1,0,0,1, 16'hABCD, 16'h0000, 0, 1, 16'h0000, 16'hABCD, 1, 0));
      drive(0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4321, 16'h0000);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      driveBubble(0);
      #1;
      check("rstclr_valid", 32'(bus2.Valid_MEMWB),    32'd0);
      check("rstclr_aluo",  32'(bus2.ALUO_MEMWB),     32'd0);
      check("rstclr_m2r",   32'(bus2.MemtoReg_MEMWB), 32'd0);

      // LATENCY=4: store, load, then a non-access directly behind the load.
      issue(1, mk("l4_store", 1,0,1,0, 16'h0040, 16'h2468, 3, 1, 16'h0000, 16'h0040, 0, 0));
      issue(1, mk("l4_load",  1,1,0,1, 16'h0040, 16'h0000, 3, 1, 16'h2468, 16'h0040, 1, 0));
      issue(1, mk("l4_pass",  1,0,0,0, 16'h1234, 16'h0000, 0, 1, 16'h0000, 16'h1234, 0, 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage_mc.md
# mem_stage_mc

Parametrised multi-cycle memory stage for the 5-stage pipeline. It sits between the EX/MEM and MEM/WB boundaries and owns the data memory as an internal word array with configurable access latency. It stalls upstream while an access is in flight and registers load data, ALU result and writeback control into the MEM/WB pipeline register. It replaces the fixed single-cycle memory stage with a width-, depth- and latency-generic stage that has a stall handshake and optional alignment checking.

## Interface
- DATA_W, 16, data word width and ALU-result width in bits
- ADDR_W, 16, width of the byte address taken from the ALU result (ADDR_W ≤ DATA_W)
- DEPTH, 1024, number of DATA_W-bit words in the array (power of two, ≥ 2)
- LATENCY, 2, cycles per memory access including the accept cycle (≥ 1)

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- ALUO_EXMEM  in  DATA_W  ALU result; low ADDR_W bits form the byte address
- Rd2_EXMEM  in  DATA_W  store data
- MemRead_EXMEM  in  1  load request
- MemWrite_EXMEM  in  1  store request
- MemtoReg_EXMEM  in  1  writeback-select control, passed through
- Valid_EXMEM  in  1  EX/MEM holds a live instruction
- Stall_MEM  out  1  combinational; upstream must hold all *_EXMEM inputs stable while high
- RdD_MEMWB  out  DATA_W  registered load data
- ALUO_MEMWB  out  DATA_W  registered ALU result
- MemtoReg_MEMWB  out  1  registered control
- Valid_MEMWB  out  1  registered; the MEM/WB register holds a live instruction
- Err_MEMWB  out  1  registered alignment fault flag

## Operation
- Access condition: Valid_EXMEM & (MemRead_EXMEM | MemWrite_EXMEM).
- Word index: ALUO_EXMEM[log2(DEPTH):1]. Byte bit 0 is the alignment bit. Higher address bits are ignored, so the address wraps modulo DEPTH.
- FSM states:
  - IDLE: on an access, if LATENCY = 1, complete in the same cycle. Otherwise capture the index and store data, load cnt = LATENCY-2, assert Stall_MEM and go to BUSY.
  - IDLE, non-access valid instruction: passes to MEM/WB in one cycle with RdD = 0.
  - BUSY: Stall_MEM stays high while cnt ≠ 0, and cnt decrements each cycle. When cnt = 0 the access completes: Stall_MEM drops, MEM/WB loads and the FSM returns to IDLE.
- A completion cycle is never also an accept cycle. The next instruction is sampled in IDLE on the following cycle.
- Store: the array is written on the completion edge. RdD_MEMWB = 0 for stores.
- Read and write both set: treated as a store. RdD_MEMWB = 0.
- Load: RdD_MEMWB = array[index] as of the completion edge. A load issued immediately after a store to the same word returns the new data.
- While Stall_MEM is high, MEM/WB loads a bubble each stalled cycle (Valid_MEMWB = 0, other MEM/WB outputs 0).
- Valid_EXMEM = 0: a bubble passes through and all MEM/WB outputs are 0.

## Timing
- Access accepted at cycle T: Stall_MEM is high for cycles T through T+LATENCY-2, and MEM/WB is valid from cycle T+LATENCY.
- Non-access instructions: 1-cycle latency, never stall.
- Reset: state = IDLE, cnt = 0, Stall_MEM = 0; RdD_MEMWB, ALUO_MEMWB, MemtoReg_MEMWB, Valid_MEMWB, Err_MEMWB = 0. Array contents are not cleared.
- Reset mid-access: the in-flight access is discarded and no write occurs, even if rst coincides with the completion edge. The FSM is in IDLE on the next cycle.

## Configuration
- MEM_ALIGN_CHECK_EN defined: an access with ALUO_EXMEM[0] = 1 does not touch the array and completes in 1 cycle with no stall. The stage registers Err_MEMWB = 1, Valid_MEMWB = 1 and RdD_MEMWB = 0.
- MEM_ALIGN_CHECK_EN undefined: bit 0 is ignored, misaligned accesses proceed normally, and Err_MEMWB is constant 0. The port is present in both builds.

## Test plan
- LATENCY=2: store 16'hBEEF at address 16'h0010, then load 16'h0010 → Stall_MEM high exactly 1 cycle per access; load returns RdD_MEMWB = 16'hBEEF with Valid_MEMWB = 1 at T+2.
- LATENCY=4: non-access instruction with ALUO = 16'h1234 directly after a load → load stalls 3 cycles; ALUO_MEMWB = 16'h1234 one cycle after the load completes, with no extra stall.
- DEPTH=1024: store 16'h00AA at address 16'h0802, load address 16'h0002 → returns 16'h00AA (address wrap).
- rst asserted during the BUSY cycle of a store of 16'h5555 to 16'h0020 (the store had overwritten a prior 16'h1111) → all outputs 0 after reset; a later load of 16'h0020 returns 16'h1111.
- MEM_ALIGN_CHECK_EN defined: load address 16'h0011 → no stall; Err_MEMWB = 1 and RdD_MEMWB = 0 next cycle. Without the macro, the same load returns the word at index 8.
- Read and write both asserted with Rd2 = 16'h0F0F at 16'h0030 → RdD_MEMWB = 0; a subsequent load of 16'h0030 returns 16'h0F0F.
